calc_display_encoder: RTL and testbench
=======================================

Name: calc_display_encoder

Overview:
- Converts the calculator's signed binary result or operand into four active-low 7-segment digit patterns.
- Uses a sequential double-dabble binary-to-BCD engine behind a load/busy/done handshake.
- Feeds the digit0_display..digit3_display inputs of the multiplexed, blinking display driver directly downstream.
- Outputs are registered and hold the last conversion until the next one completes.

Parameters:
- WIDTH, 15: width of the two's-complement input value; legal values 15..16. SHIFT runs WIDTH cycles.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  start conversion; sampled only in IDLE
- value  in  WIDTH  signed two's-complement number to show
- err_in  in  1  upstream error flag (e.g. divide by zero); sampled with load
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; new digit patterns valid
- digit0_display  out  8  rightmost digit pattern
- digit1_display  out  8  second digit from right
- digit2_display  out  8  third digit from right
- digit3_display  out  8  leftmost digit pattern

Behaviour:
- Segment encoding: active-low, bit order {dp,g,f,e,d,c,b,a}. The dp bit is always 1.
  - 0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8, 8=8'h80, 9=8'h90
  - minus=8'hBF, E=8'h86, r=8'hAF, blank=8'hFF
- Reset (async, any state): state=IDLE; busy=0; done=0; all four digit outputs=8'hFF. A reset during a conversion aborts it and no done is produced.
- FSM states: IDLE, PREP, SHIFT, ENCODE.
  - IDLE: if load=1 at an edge (E0), capture value and err_in, then go to PREP; busy=1 from E0.
  - PREP (1 cycle): compute neg=value[WIDTH-1] and mag=|value| (WIDTH bits, unsigned). Set error = err_in OR value>9999 OR value<-999. Clear the 16-bit BCD register and shift counter.
  - SHIFT (exactly WIDTH cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1. Runs the full count even when error=1, so latency is fixed.
  - ENCODE (1 cycle): on the exit edge, write all four digit outputs together, pulse done=1 for one cycle, set busy=0, and return to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH+2, which is 17 edges for WIDTH=15. Digit outputs change only on that edge.
- Encoding rules:
  - error=1: digit3..0 = E, r, r, blank.
  - Otherwise, leading-zero handling and minus placement follow the optional feature below.
  - A value of 0 always shows a single 0 on digit0.
  - -0 cannot occur; the most negative WIDTH value is caught by the range check.
- Handshake:
  - load while busy=1 is ignored (not queued).
  - load in the done cycle is accepted, because the FSM is already in IDLE.
  - A load pulse longer than one cycle starts one conversion, then a second one on the IDLE edge after done. Upstream is required to pulse.
- Outputs are never partially updated. Between conversions, digit outputs stay constant.

Optional Feature:
- Macro: DISP_ZERO_BLANK_EN.
- Defined:
  - Leading zeros above the most significant nonzero digit are blank (8'hFF).
  - For negative values, the minus sits in the digit immediately left of the most significant digit. Example: -5 shows blank, blank, minus, 5.
- Undefined:
  - All non-error digits are shown with leading zeros. Example: 42 shows 0,0,4,2.
  - Negative values put the minus on digit3 with magnitude on digits 2..0. Example: -5 shows minus, 0, 0, 5.
  - Magnitude >999 with neg=1 is already an error.
- Range check, latency and error display are identical in both builds.

Test Plan:
- Reset, then pulse load with value=1234 -> done exactly 17 edges after load; digits3..0 = F9,A4,B0,99; busy high through the conversion.
- DISP_ZERO_BLANK_EN defined, value=-5 -> digits3..0 = FF,FF,BF,92. Undefined -> BF,C0,C0,92.
- value=10000, and separately value=-1000, and separately value=7 with err_in=1 -> digits3..0 = 86,AF,AF,FF in every case.
- value=0 -> digit0=C0. Blanked build: digits3..1 = FF. Unblanked build: digits3..1 = C0.
- Pulse load mid-conversion -> ignored; one done only, carrying the first value. Load asserted in the done cycle -> second conversion done 17 edges later.
- Assert rst in SHIFT cycle 5 -> busy=0, done=0 and digits=FF immediately (async). No done appears afterward; the next load converts normally.

Source files
------------

// File: rtl/calc_display_encoder.sv
// Signed binary value to four active-low 7-segment digit patterns through a sequential
// double-dabble engine. Optional build macro DISP_ZERO_BLANK_EN blanks leading zeros.
module calc_display_encoder #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             err_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       digit0_display,
    output logic [7:0]       digit1_display,
    output logic [7:0]       digit2_display,
    output logic [7:0]       digit3_display
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic signed [WIDTH-1:0] MAX_VAL = WIDTH'(9999);
    localparam logic signed [WIDTH-1:0] MIN_VAL = WIDTH'(-999);

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {IDLE, PREP, SHIFT, ENCODE} state_t;

    state_t state_r, state_next;

    logic signed [WIDTH-1:0] value_cap;
    logic                    err_cap;
    logic                    neg_r;
    logic                    error_r;
    logic [WIDTH-1:0]        mag_r;
    logic [WIDTH-1:0]        mag_abs;
    logic [15:0]             bcd_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [31:0]             enc;
    logic [31:0]             disp_q;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 8'hC0;
            4'd1:    seg_encode = 8'hF9;
            4'd2:    seg_encode = 8'hA4;
            4'd3:    seg_encode = 8'hB0;
            4'd4:    seg_encode = 8'h99;
            4'd5:    seg_encode = 8'h92;
            4'd6:    seg_encode = 8'h82;
            4'd7:    seg_encode = 8'hF8;
            4'd8:    seg_encode = 8'h80;
            4'd9:    seg_encode = 8'h90;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

    assign mag_abs = value_cap[WIDTH-1] ? $unsigned(-value_cap) : $unsigned(value_cap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next;
    end

    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    if (load) state_next = PREP;
            PREP:    state_next = SHIFT;
            SHIFT:   if (cnt_r == LAST_SHIFT) state_next = ENCODE;
            ENCODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, prepare magnitude, then shift WIDTH times regardless of error
    always_ff @(posedge clk) begin
        case (state_r)
            IDLE: begin
                if (load) begin
                    value_cap <= $signed(value);
                    err_cap   <= err_in;
                end
            end
            PREP: begin
                neg_r   <= value_cap[WIDTH-1];
                mag_r   <= mag_abs;
                error_r <= err_cap || (value_cap > MAX_VAL) || (value_cap < MIN_VAL);
                bcd_r   <= '0;
                cnt_r   <= '0;
            end
            SHIFT: begin
                {bcd_r, mag_r} <= {dabble_adjust(bcd_r), mag_r} << 1;
                cnt_r          <= cnt_r + 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DISP_ZERO_BLANK_EN
    int msd;
`endif

    always_comb begin
        enc = {4{SEG_BLANK}};
`ifdef DISP_ZERO_BLANK_EN
        msd = 0;
        for (int i = 1; i < 4; i++) begin
            if (bcd_r[i*4 +: 4] != 4'd0) msd = i;
        end
`endif
        if (error_r) begin
            enc = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
        end else begin
`ifdef DISP_ZERO_BLANK_EN
            // Digits above the leading nonzero digit stay blank; minus hugs the number
            for (int i = 0; i < 4; i++) begin
                if (i <= msd)
                    enc[i*8 +: 8] = seg_encode(bcd_r[i*4 +: 4]);
                else if (neg_r && (i == msd + 1))
                    enc[i*8 +: 8] = SEG_MINUS;
            end
`else
            for (int i = 0; i < 4; i++) begin
                enc[i*8 +: 8] = seg_encode(bcd_r[i*4 +: 4]);
            end
            if (neg_r) enc[31:24] = SEG_MINUS;
`endif
        end
    end

    // Output register: all four digits and done change together on the ENCODE exit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            disp_q <= {4{SEG_BLANK}};
        end else begin
            done <= (state_r == ENCODE);
            if (state_r == ENCODE) disp_q <= enc;
        end
    end

    assign busy           = (state_r != IDLE);
    assign digit0_display = disp_q[7:0];
    assign digit1_display = disp_q[15:8];
    assign digit2_display = disp_q[23:16];
    assign digit3_display = disp_q[31:24];

endmodule

// File: tb/tb_calc_display_encoder.sv
// Randomized self-checking bench for calc_display_encoder against a decimal-arithmetic
// reference model; honours DISP_ZERO_BLANK_EN the same way as the design.
module tb_calc_display_encoder;

    localparam int WIDTH = 15;
    localparam int LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] value;
    logic             err_in;
    logic             busy;
    logic             done;
    logic [7:0]       d0, d1, d2, d3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    calc_display_encoder #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .value          (value),
        .err_in         (err_in),
        .busy           (busy),
        .done           (done),
        .digit0_display (d0),
        .digit1_display (d1),
        .digit2_display (d2),
        .digit3_display (d3)
    );

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference: decimal digits by division, leading-digit count by magnitude thresholds
    function automatic logic [31:0] model(input int v, input bit e);
        logic [7:0] d [4];
        int m, nd, pw;
        bit neg;
        if (e || v > 9999 || v < -999) return 32'h86AFAFFF;
        neg = (v < 0);
        m   = neg ? -v : v;
        nd  = (m >= 1000) ? 4 : (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
        pw  = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef DISP_ZERO_BLANK_EN
            if (i < nd)                d[i] = seg_of((m / pw) % 10);
            else if (neg && i == nd)   d[i] = 8'hBF;
            else                       d[i] = 8'hFF;
`else
            d[i] = seg_of((m / pw) % 10);
`endif
            pw = pw * 10;
        end
`ifndef DISP_ZERO_BLANK_EN
        if (neg) d[3] = 8'hBF;
`endif
        return {d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [31:0] shown();
        return {d3, d2, d1, d0};
    endfunction

    // Call between edges; returns just after the load edge E0
    task automatic start_load(input int v, input bit e);
        load   = 1'b1;
        value  = v[WIDTH-1:0];
        err_in = e;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; records whether busy stayed high before it
    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = '0; err_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_total++;
        if (shown() !== 32'hFFFFFFFF) $display("FAIL reset_digits got=%h exp=ffffffff", shown());
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_1234();
        int lat; bit bok; logic [31:0] held;
        start_load(1234, 1'b0);
        n_total++; if (busy !== 1'b1) $display("FAIL busy_after_load got=%b exp=1", busy); else n_pass++;
        wait_done(lat, bok);
        n_total++; if (lat !== LAT) $display("FAIL latency_1234 got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_total++; if (bok !== 1'b1) $display("FAIL busy_through_conv got=%b exp=1", bok); else n_pass++;
        n_total++;
        if (shown() !== 32'hF9A4B099) $display("FAIL digits_1234 got=%h exp=f9a4b099", shown());
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_in_done got=%b exp=0", busy); else n_pass++;
        held = shown();
        @(posedge clk);
        #1;
        n_total++; if (done !== 1'b0) $display("FAIL done_one_cycle got=%b exp=0", done); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (shown() !== held) $display("FAIL digits_hold got=%h exp=%h", shown(), held); else n_pass++;
    endtask

    task automatic test_negative();
        int lat; bit bok; logic [31:0] exp_v;
`ifdef DISP_ZERO_BLANK_EN
        exp_v = 32'hFFFFBF92;
`else
        exp_v = 32'hBFC0C092;
`endif
        start_load(-5, 1'b0);
        wait_done(lat, bok);
        n_total++; if (shown() !== exp_v) $display("FAIL digits_neg5 got=%h exp=%h", shown(), exp_v); else n_pass++;
    endtask

    task automatic test_zero();
        int lat; bit bok; logic [31:0] exp_v;
`ifdef DISP_ZERO_BLANK_EN
        exp_v = 32'hFFFFFFC0;
`else
        exp_v = 32'hC0C0C0C0;
`endif
        start_load(0, 1'b0);
        wait_done(lat, bok);
        n_total++; if (shown() !== exp_v) $display("FAIL digits_zero got=%h exp=%h", shown(), exp_v); else n_pass++;
    endtask

    task automatic test_errors();
        int vals [3] = '{10000, -1000, 7};
        bit errs [3] = '{1'b0, 1'b0, 1'b1};
        int lat; bit bok;
        for (int k = 0; k < 3; k++) begin
            start_load(vals[k], errs[k]);
            wait_done(lat, bok);
            n_total++;
            if (shown() !== 32'h86AFAFFF)
                $display("FAIL digits_err v=%0d e=%0b got=%h exp=86afafff", vals[k], errs[k], shown());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int v, lat; bit e, bok; logic [31:0] exp_v;
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 0)
                v = int'($urandom_range(0, 10998)) - 999;
            else
                v = int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
            e = ($urandom_range(0, 7) == 0);
            exp_v = model(v, e);
            start_load(v, e);
            wait_done(lat, bok);
            n_total++; if (lat !== LAT) $display("FAIL latency_rand v=%0d got=%0d exp=%0d", v, lat, LAT); else n_pass++;
            n_total++;
            if (shown() !== exp_v) $display("FAIL digits_rand v=%0d e=%0b got=%h exp=%h", v, e, shown(), exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_load_while_busy();
        int lat, n; bit bok;
        start_load(321, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        load = 1'b1; value = WIDTH'(999); err_in = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(lat, bok);
        n_total++;
        if (shown() !== model(321, 1'b0)) $display("FAIL busy_load_digits got=%h exp=%h", shown(), model(321, 1'b0));
        else n_pass++;
        count_dones(30, n);
        n_total++; if (n !== 0) $display("FAIL busy_load_extra_done got=%0d exp=0", n); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        start_load(4321, 1'b0);
        wait_done(lat, bok);
        n_total++;
        if (shown() !== model(4321, 1'b0)) $display("FAIL b2b_first got=%h exp=%h", shown(), model(4321, 1'b0));
        else n_pass++;
        start_load(-77, 1'b0);
        wait_done(lat, bok);
        n_total++; if (lat !== LAT) $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_total++;
        if (shown() !== model(-77, 1'b0)) $display("FAIL b2b_second got=%h exp=%h", shown(), model(-77, 1'b0));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, n; bit bok;
        start_load(2468, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else n_pass++;
        n_total++;
        if (shown() !== 32'hFFFFFFFF) $display("FAIL midrst_digits got=%h exp=ffffffff", shown());
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_dones(30, n);
        n_total++; if (n !== 0) $display("FAIL midrst_stray_done got=%0d exp=0", n); else n_pass++;
        start_load(55, 1'b0);
        wait_done(lat, bok);
        n_total++; if (lat !== LAT) $display("FAIL postrst_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_total++;
        if (shown() !== model(55, 1'b0)) $display("FAIL postrst_digits got=%h exp=%h", shown(), model(55, 1'b0));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_1234();
        test_negative();
        test_zero();
        test_errors();
        test_random();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
